// File: rtl/onehot_scan_pkg.sv
// onehot_scan_pkg: shared state type, index-width helper and find-first-set function for onehot_scan_encoder
package onehot_scan_pkg;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_IDX_W = $clog2(MAX_WIDTH);
  typedef enum logic {IDLE, SCAN} scan_state_t;
  function automatic int idx_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction
  function automatic logic [MAX_IDX_W-1:0] find_first(input logic [MAX_WIDTH-1:0] vec, input bit msb_first);
    logic [MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WIDTH; i++)
      if (msb_first ? vec[i] : vec[MAX_WIDTH-1-i]) r = msb_first ? MAX_IDX_W'(i) : MAX_IDX_W'(MAX_WIDTH-1-i);
    return r;
  endfunction
endpackage

// File: rtl/first_set_index.sv
// first_set_index: combinational find-first-set over vec (LSB or MSB first per MSB_FIRST); idx = first set bit, one_hot = exactly one bit set
module first_set_index import onehot_scan_pkg::*; #(
  parameter int WIDTH = 16,
  parameter bit MSB_FIRST = 1'b0,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             one_hot
);
  assign idx = IDX_W'(find_first(MAX_WIDTH'(vec), MSB_FIRST));
  assign one_hot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
endmodule

// File: rtl/onehot_scan_encoder.sv
// onehot_scan_encoder: accepts a WIDTH-bit request vector (in_valid/in_ready/in_data) and emits one index per beat
//   (out_valid/out_ready/out_idx/out_last/out_seq); zero_drop pulses when an all-zero vector is accepted; busy = scanning.
//   Define SCAN_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
//   in_ready is combinational from out_ready so a new vector can load on the last beat without a bubble.
module onehot_scan_encoder import onehot_scan_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [IDX_W:0]   out_seq,
  output logic             zero_drop,
  output logic             busy
);
`ifdef SCAN_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif
  scan_state_t state, state_next;
  logic [WIDTH-1:0] pending, pending_next;
  logic [IDX_W:0] seq_next;
  logic accept, load, beat, done;
  first_set_index #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)) u_ffs (
    .vec(pending),
    .idx(out_idx),
    .one_hot(out_last)
  );
  assign out_valid = state == SCAN;
  assign busy = state == SCAN;
  assign beat = out_valid && out_ready;
  assign done = beat && out_last;
  assign in_ready = (state == IDLE) || done;
  assign accept = in_valid && in_ready;
  assign load = accept && (in_data != '0);
  always_comb begin
    state_next = load ? SCAN : done ? IDLE : state;
    pending_next = load ? in_data : beat ? pending & ~(WIDTH'(1) << out_idx) : pending;
    seq_next = (load || done) ? '0 : beat ? out_seq + (IDX_W+1)'(1) : out_seq;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      out_seq <= '0;
      zero_drop <= 1'b0;
    end else begin
      state <= state_next;
      pending <= pending_next;
      out_seq <= seq_next;
      zero_drop <= accept && (in_data == '0);
    end
  end
endmodule

// File: tb/tb_onehot_scan_encoder.sv
// tb_onehot_scan_encoder: table-driven and directed checks of onehot_scan_encoder at WIDTH=16
module tb_onehot_scan_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [3:0] out_idx;
  logic out_last;
  logic [4:0] out_seq;
  logic zero_drop;
  logic busy;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [15:0] data;
    int n;
    logic [63:0] idxs;
  } vec_t;
  vec_t tbl[7];
  onehot_scan_encoder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .out_seq(out_seq), .zero_drop(zero_drop), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [3:0] exp_idx(input vec_t v, input int k);
    logic [63:0] t;
    t = v.idxs;
`ifdef SCAN_MSB_FIRST_EN
    return t[4*(v.n-1-k) +: 4];
`else
    return t[4*k +: 4];
`endif
  endfunction
  task automatic run_vec(input vec_t v);
    in_valid = 1'b1;
    in_data = v.data;
    out_ready = 1'b1;
    chk("accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < v.n; k++) begin
      chk("beat_valid", 32'(out_valid), 32'd1);
      chk("beat_idx", 32'(out_idx), 32'(exp_idx(v, k)));
      chk("beat_seq", 32'(out_seq), 32'(k));
      chk("beat_last", 32'(out_last), 32'(k == v.n - 1));
      tick();
    end
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_seq", 32'(out_seq), 32'd0);
  endtask
  initial begin
    vec_t v;
    tbl[0] = '{16'h8421, 4, 64'hFA50};
    tbl[1] = '{16'h0006, 2, 64'h21};
    tbl[2] = '{16'h0001, 1, 64'h0};
    tbl[3] = '{16'h8000, 1, 64'hF};
    tbl[4] = '{16'h0180, 2, 64'h87};
    tbl[5] = '{16'h0003, 2, 64'h10};
    tbl[6] = '{16'hFFFF, 16, 64'hFEDCBA9876543210};
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zero_drop", 32'(zero_drop), 32'd0);
    chk("rst_seq", 32'(out_seq), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 7; i++) run_vec(tbl[i]);
    in_valid = 1'b1;
    in_data = 16'h0000;
    tick();
    in_valid = 1'b0;
    chk("zero_pulse", 32'(zero_drop), 32'd1);
    chk("zero_no_valid", 32'(out_valid), 32'd0);
    chk("zero_ready", 32'(in_ready), 32'd1);
    tick();
    chk("zero_pulse_end", 32'(zero_drop), 32'd0);
    chk("zero_still_idle", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = 16'h0006;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_idx", 32'(out_idx), 32'(exp_idx(tbl[1], 0)));
      chk("stall_seq", 32'(out_seq), 32'd0);
      chk("stall_last", 32'(out_last), 32'd0);
      chk("stall_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("stall_beat0", 32'(out_idx), 32'(exp_idx(tbl[1], 0)));
    tick();
    chk("stall_beat1", 32'(out_idx), 32'(exp_idx(tbl[1], 1)));
    chk("stall_beat1_last", 32'(out_last), 32'd1);
    tick();
    chk("stall_done", 32'(out_valid), 32'd0);
    v = '{16'h0300, 2, 64'h98};
    in_valid = 1'b1;
    in_data = 16'h0001;
    tick();
    in_data = 16'h0300;
    chk("b2b_idx0", 32'(out_idx), 32'd0);
    chk("b2b_last0", 32'(out_last), 32'd1);
    chk("b2b_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_no_bubble", 32'(out_valid), 32'd1);
    chk("b2b_idx1", 32'(out_idx), 32'(exp_idx(v, 0)));
    chk("b2b_seq1", 32'(out_seq), 32'd0);
    tick();
    chk("b2b_idx2", 32'(out_idx), 32'(exp_idx(v, 1)));
    chk("b2b_seq2", 32'(out_seq), 32'd1);
    chk("b2b_last2", 32'(out_last), 32'd1);
    tick();
    chk("b2b_done", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    chk("busy_ready_low", 32'(in_ready), 32'd0);
    tick();
    tick();
    tick();
    chk("pre_rst_seq", 32'(out_seq), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_seq", 32'(out_seq), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_stays_idle", 32'(out_valid), 32'd0);
    run_vec(tbl[5]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
